// File: rtl/keyword_tokenizer_if.sv
// keyword_tokenizer_if: byte-in / token-out handshake bundle.
//   in, in_valid, in_last, in_ready : ASCII byte stream (valid/ready)
//   tok, tok_valid, tok_ready       : classified word tokens (valid/ready)
//   tok_count                       : token FIFO occupancy
// master = stream source / token sink, slave = tokenizer.
interface keyword_tokenizer_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    in;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [1:0]    tok;
    logic          tok_valid;
    logic          tok_ready;
    logic [CW-1:0] tok_count;

    modport master (
        output in, in_valid, in_last, tok_ready,
        input  in_ready, tok, tok_valid, tok_count
    );

    modport slave (
        input  in, in_valid, in_last, tok_ready,
        output in_ready, tok, tok_valid, tok_count
    );
endinterface

// File: rtl/keyword_tokenizer.sv
// keyword_tokenizer: folds case on an ASCII byte stream, splits it into
// words and queues one token per word (BEGIN=01, END=10, OTHER=11) in a
// small FIFO for the downstream nesting checker.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : keyword_tokenizer_if.slave (byte stream in, token stream out)
// Parameter FIFO_DEPTH: token FIFO entries, power of two, >= 2.
// Optional macro KEYWORD_TOKENIZER_DIGIT_EN: when defined, 0-9 count as
// word characters; otherwise digits are separators.
module keyword_tokenizer #(
    parameter int FIFO_DEPTH = 4
) (
    input logic                 clk,
    input logic                 reset,
    keyword_tokenizer_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [3:0] {
        IDLE, B1, B2, B3, B4, B5, E1, E2, E3, OTH
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [1:0]    mem_q [FIFO_DEPTH];
    logic [1:0]    mem_d [FIFO_DEPTH];

    logic [7:0]    lc;
    logic          is_upper, is_letter, is_digit, is_word;
    logic          full, empty, accept, pop, push;
    logic [1:0]    push_tok;
    state_t        adv;

    // Token a word would produce if it ended in state s (s != IDLE).
    function automatic logic [1:0] tok_of(state_t s);
        case (s)
            B5:      return 2'b01;
            E3:      return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    assign is_upper  = (bus.in >= "A") && (bus.in <= "Z");
    assign lc        = is_upper ? bus.in + 8'h20 : bus.in;
    assign is_letter = (lc >= "a") && (lc <= "z");
`ifdef KEYWORD_TOKENIZER_DIGIT_EN
    assign is_digit  = (bus.in >= "0") && (bus.in <= "9");
`else
    assign is_digit  = 1'b0;
`endif
    assign is_word   = is_letter | is_digit;

    // Full: same index, opposite wrap bit. Empty: identical pointers.
    assign full   = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
    assign empty  = (wr_ptr_q == rd_ptr_q);

    // in_ready ignores a same-cycle pop so the input path never depends
    // on tok_ready combinationally.
    assign bus.in_ready  = reset & ~full;
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.tok_valid = ~empty;
    assign pop           = ~empty & bus.tok_ready;
    assign bus.tok       = mem_q[rd_ptr_q[AW-1:0]];
    assign bus.tok_count = wr_ptr_q - rd_ptr_q;

    // Prefix matcher: next state for a word character.
    always_comb begin
        adv = OTH;
        case (state_q)
            IDLE:    adv = (lc == "b") ? B1 : (lc == "e") ? E1 : OTH;
            B1:      adv = (lc == "e") ? B2 : OTH;
            B2:      adv = (lc == "g") ? B3 : OTH;
            B3:      adv = (lc == "i") ? B4 : OTH;
            B4:      adv = (lc == "n") ? B5 : OTH;
            E1:      adv = (lc == "n") ? E2 : OTH;
            E2:      adv = (lc == "d") ? E3 : OTH;
            default: adv = OTH;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        push     = 1'b0;
        push_tok = 2'b11;
        if (accept) begin
            if (is_word) begin
                state_d = adv;
                // in_last closes the word as if a separator followed.
                if (bus.in_last) begin
                    push     = 1'b1;
                    push_tok = tok_of(adv);
                    state_d  = IDLE;
                end
            end else begin
                if (state_q != IDLE) begin
                    push     = 1'b1;
                    push_tok = tok_of(state_q);
                end
                state_d = IDLE;
            end
        end
    end

    // accept implies !full, so a push can never overwrite a live entry.
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q[AW-1:0]] = push_tok;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 2'b11;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end
endmodule
